serial_paralelo_param: RTL and testbench
========================================

# serial_paralelo_param

Parametrised serial-to-parallel receiver for the PCIe-style physical layer. It deserialises a single-bit stream on the bit clock with no word clock, and finds word alignment at any bit offset by hunting for a comma symbol. It declares the link active after a programmable number of aligned commas, and delivers non-comma words with a one-cycle valid strobe. It also detects loss of alignment and drops back to hunting on its own, which the fixed 8-bit predecessor could not do.

## Interface
Parameters:
- WIDTH, 8, word width in bits (≥4).
- COMMA, 8'hBC, alignment/idle symbol, WIDTH bits.
- LOCK_COMMAS, 4, aligned commas required to enter ACTIVE (≥1).
- MAX_ERR, 3, off-boundary comma detections that force re-hunt (≥1).

Ports:
- clk_32f  in  1  bit clock; all state updates on posedge. One clock; reset is asynchronous and active-low.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- data_in  in  1  serial data, MSB of each word first, sampled on posedge clk_32f.
- data2send  out  WIDTH  last completed word in ACTIVE; first received bit at bit WIDTH-1.
- valid_out  out  1  one-cycle pulse: data2send holds a new non-comma word.
- word_strobe  out  1  one-cycle pulse at every word boundary in ACTIVE, commas included.
- active  out  1  high while in state ACTIVE.

## Operation
- Shift register shreg[WIDTH-1:0] loads {shreg[WIDTH-2:0], data_in} every cycle. The combinational window is that same next value.
- bit_cnt (0..WIDTH-1) increments and wraps. A word boundary is the cycle where bit_cnt == WIDTH-1.
- comma_cnt counts aligned commas and saturates at LOCK_COMMAS. err_cnt counts misaligned commas and saturates at MAX_ERR.
- States:
  - HUNT:
    - Checked every cycle, not only at boundaries.
    - window == COMMA: bit_cnt <= 0 (next bit starts a word), comma_cnt <= 1, then ALIGN. If LOCK_COMMAS == 1, go straight to ACTIVE.
  - ALIGN:
    - Checked only at boundaries.
    - window == COMMA: comma_cnt++. On reaching LOCK_COMMAS, go to ACTIVE with err_cnt <= 0.
    - Non-comma window at a boundary: comma_cnt <= 0, go to HUNT.
  - ACTIVE, at a boundary:
    - data2send <= window and word_strobe <= 1.
    - valid_out <= (window != COMMA).
    - A comma at the boundary clears err_cnt.
  - ACTIVE, off a boundary:
    - window == COMMA: err_cnt++. On reaching MAX_ERR, go to HUNT; active falls and comma_cnt is cleared.
    - A HUNT match in that same cycle is not taken. Hunting resumes the next cycle.
- data2send holds its value outside boundaries and after leaving ACTIVE.
- Data words equal to COMMA are never flagged valid.
- Random off-boundary comma aliasing in data is tolerated below MAX_ERR.

## Timing
- Reset values (async, while reset low):
  - data2send = 0, valid_out = 0, word_strobe = 0, active = 0.
  - State HUNT; shreg, bit_cnt, comma_cnt, err_cnt all 0.
- Latency:
  - The posedge that samples a word's last bit also registers data2send, valid_out and word_strobe.
  - They are visible immediately after that edge, for exactly one cycle (valid_out and word_strobe).
- active rises on the edge sampling the last bit of the LOCK_COMMAS-th aligned comma, and falls on the edge of the MAX_ERR-th misaligned comma.
- In ACTIVE, strobes are exactly WIDTH cycles apart. A new pulse always lands on a boundary.
- Reset release:
  - Sampling starts on the first posedge with reset high.
  - Reset asserted mid-word discards the partial word with no strobe.

## Test plan
- Reset: drive reset=0 mid-stream. All outputs go to 0 asynchronously, before the next clock edge, and stay 0 until hunting restarts.
- Lock at offset 3: send 3 junk bits, then BC×4, then A5 (WIDTH=8).
  - active rises on the 35th sampled bit.
  - 8 cycles later, valid_out pulses once with data2send=8'hA5 and word_strobe=1.
- Failed lock: send BC, BC, 8'h12. No active, no valid_out. A following BC×4 locks normally.
- Idle commas in ACTIVE: send BC between data words 3C, 7E.
  - word_strobe pulses every 8 cycles.
  - valid_out pulses only for 3C and 7E.
  - data2send=BC during comma words.
- Bit slip: after lock, insert one extra bit, then send BC continuously.
  - The 3rd misaligned BC drops active.
  - The next BC×4 relocks at the new phase; active rises again.
- Saturation/recovery in ACTIVE: misaligned comma, aligned BC, misaligned comma, misaligned comma. err_cnt clears on the aligned BC and active stays 1.

Source files
------------

// File: rtl/serial_paralelo_param_if.sv
// Serial receiver bus: the serial bit input plus the recovered word, its strobes and link state.
interface serial_paralelo_param_if #(
   parameter int WIDTH = 8
);
   logic             data_in;
   logic [WIDTH-1:0] data2send;
   logic             valid_out;
   logic             word_strobe;
   logic             active;

   modport master (
      output data_in,
      input  data2send,
      input  valid_out,
      input  word_strobe,
      input  active
   );

   modport slave (
      input  data_in,
      output data2send,
      output valid_out,
      output word_strobe,
      output active
   );
endinterface

// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel receiver: hunts for a comma at any bit offset, locks after LOCK_COMMAS
// aligned commas and falls back to hunting after MAX_ERR commas seen off the word boundary.
module serial_paralelo_param #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] COMMA       = WIDTH'(8'hBC),
   parameter int               LOCK_COMMAS = 4,
   parameter int               MAX_ERR     = 3
) (
   input  logic                   clk_32f,
   input  logic                   reset,
   serial_paralelo_param_if.slave bus
);
   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_COMMAS + 1);
   localparam int EW = $clog2(MAX_ERR + 1);

   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [CW-1:0] LOCK_N   = CW'(LOCK_COMMAS);
   localparam logic [EW-1:0] MAX_N    = EW'(MAX_ERR);

   typedef enum logic [1:0] {
      HUNT,
      ALIGN,
      ACTIVE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
   logic [EW-1:0]    err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             strobe_q, strobe_d;

   logic [WIDTH-1:0] window;
   logic             is_comma;
   logic             boundary;
   logic [CW-1:0]    comma_inc;
   logic [EW-1:0]    err_inc;

   // The window already includes the bit being sampled this cycle.
   assign window    = {shreg_q[WIDTH-2:0], bus.data_in};
   assign is_comma  = (window == COMMA);
   assign boundary  = (bit_cnt_q == LAST_BIT);
   assign comma_inc = (comma_cnt_q == LOCK_N) ? comma_cnt_q : comma_cnt_q + CW'(1);
   assign err_inc   = (err_cnt_q == MAX_N) ? err_cnt_q : err_cnt_q + EW'(1);

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT: begin
            if (is_comma) begin
               state_d = (LOCK_COMMAS == 1) ? ACTIVE : ALIGN;
            end
         end
         ALIGN: begin
            if (boundary) begin
               if (!is_comma) begin
                  state_d = HUNT;
               end else if (comma_inc == LOCK_N) begin
                  state_d = ACTIVE;
               end
            end
         end
         ACTIVE: begin
            if (!boundary && is_comma && (err_inc == MAX_N)) begin
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Counters and word outputs; strobes default low so they last exactly one cycle.
   always_comb begin
      shreg_d     = window;
      bit_cnt_d   = boundary ? '0 : bit_cnt_q + BW'(1);
      comma_cnt_d = comma_cnt_q;
      err_cnt_d   = err_cnt_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      strobe_d    = 1'b0;
      case (state_q)
         HUNT: begin
            if (is_comma) begin
               bit_cnt_d   = '0;
               comma_cnt_d = CW'(1);
               if (LOCK_COMMAS == 1) begin
                  err_cnt_d = '0;
               end
            end
         end
         ALIGN: begin
            if (boundary) begin
               if (is_comma) begin
                  comma_cnt_d = comma_inc;
                  if (comma_inc == LOCK_N) begin
                     err_cnt_d = '0;
                  end
               end else begin
                  comma_cnt_d = '0;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               data_d   = window;
               strobe_d = 1'b1;
               valid_d  = !is_comma;
               if (is_comma) begin
                  err_cnt_d = '0;
               end
            end else if (is_comma) begin
               err_cnt_d = err_inc;
               if (err_inc == MAX_N) begin
                  comma_cnt_d = '0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         comma_cnt_q <= '0;
         err_cnt_q   <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         err_cnt_q   <= err_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         strobe_q    <= strobe_d;
      end
   end

   assign bus.data2send   = data_q;
   assign bus.valid_out   = valid_q;
   assign bus.word_strobe = strobe_q;
   assign bus.active      = (state_q == ACTIVE);
endmodule

// File: tb/tb_serial_paralelo_param.sv
// Bench for serial_paralelo_param: directed link scenarios plus random words, every sampled
// bit checked against a bit-history reference model of the receiver.
module tb_serial_paralelo_param;
   localparam int         WIDTH = 8;
   localparam logic [7:0] COMMA = 8'hBC;
   localparam int         LOCK  = 4;
   localparam int         MAXE  = 3;

   localparam int M_HUNT   = 0;
   localparam int M_ALIGN  = 1;
   localparam int M_ACTIVE = 2;

   logic clk_32f = 1'b0;
   logic reset;

   serial_paralelo_param_if #(.WIDTH(WIDTH)) bus ();

   serial_paralelo_param #(
      .WIDTH(WIDTH),
      .COMMA(COMMA),
      .LOCK_COMMAS(LOCK),
      .MAX_ERR(MAXE)
   ) dut (
      .clk_32f(clk_32f),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clk_32f = ~clk_32f;

   int checks = 0;
   int errors = 0;

   int mMode, mWin, mBits, mAlignAt, mCommas, mErrs, mData;
   int mValid, mStrobe;
   int seenValid, seenStrobe;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mMode = M_HUNT; mWin = 0; mBits = 0; mAlignAt = 0;
      mCommas = 0; mErrs = 0; mData = 0; mValid = 0; mStrobe = 0;
   endtask

   // Word boundaries are every WIDTH bits counted from the bit that completed the hunted comma.
   task automatic modelStep(input logic b);
      bit onBoundary;
      mWin = ((mWin * 2) + int'(b)) % (1 << WIDTH);
      mBits++;
      mValid = 0;
      mStrobe = 0;
      onBoundary = (mBits > mAlignAt) && (((mBits - mAlignAt) % WIDTH) == 0);
      if (mMode == M_HUNT) begin
         if (mWin == int'(COMMA)) begin
            mAlignAt = mBits;
            mCommas = 1;
            mMode = (LOCK == 1) ? M_ACTIVE : M_ALIGN;
            if (LOCK == 1) mErrs = 0;
         end
      end else if (mMode == M_ALIGN) begin
         if (onBoundary) begin
            if (mWin == int'(COMMA)) begin
               mCommas++;
               if (mCommas == LOCK) begin
                  mMode = M_ACTIVE;
                  mErrs = 0;
               end
            end else begin
               mCommas = 0;
               mMode = M_HUNT;
            end
         end
      end else begin
         if (onBoundary) begin
            mData = mWin;
            mStrobe = 1;
            mValid = (mWin != int'(COMMA)) ? 1 : 0;
            if (mWin == int'(COMMA)) mErrs = 0;
         end else if (mWin == int'(COMMA)) begin
            mErrs++;
            if (mErrs >= MAXE) begin
               mMode = M_HUNT;
               mCommas = 0;
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic b);
      @(negedge clk_32f);
      bus.data_in = b;
      @(posedge clk_32f);
      #1;
      modelStep(b);
      checkOutput("data2send", bus.data2send, mData);
      checkOutput("valid_out", bus.valid_out, mValid);
      checkOutput("word_strobe", bus.word_strobe, mStrobe);
      checkOutput("active", bus.active, (mMode == M_ACTIVE) ? 1 : 0);
      if (bus.valid_out === 1'b1) seenValid++;
      if (bus.word_strobe === 1'b1) seenStrobe++;
   endtask

   task automatic sendWord(input logic [7:0] w);
      for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(w[i]);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_data"}, bus.data2send, 0);
      checkOutput({tag, "_valid"}, bus.valid_out, 0);
      checkOutput({tag, "_strobe"}, bus.word_strobe, 0);
      checkOutput({tag, "_active"}, bus.active, 0);
   endtask

   // Pulls reset between clock edges and expects the outputs to clear without a clock.
   task automatic midStreamReset();
      #2;
      reset = 1'b0;
      #1;
      checkAllZero("async_rst");
      modelReset();
      repeat (2) @(posedge clk_32f);
      #1;
      checkAllZero("held_rst");
      @(negedge clk_32f);
      bus.data_in = 1'b0;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      bus.data_in = 1'b0;
      modelReset();
      #12;
      checkAllZero("rst");
      @(negedge clk_32f);
      reset = 1'b1;

      $display("[TB] lock at offset 3");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0);
      for (int i = 0; i < 3; i++) sendWord(COMMA);
      for (int i = 7; i >= 1; i--) applyStimulus(COMMA[i]);
      checkOutput("prelock_active", bus.active, 0);
      applyStimulus(COMMA[0]);
      checkOutput("lock35_active", bus.active, 1);
      seenValid = 0;
      sendWord(8'hA5);
      checkOutput("a5_valid", bus.valid_out, 1);
      checkOutput("a5_strobe", bus.word_strobe, 1);
      checkOutput("a5_data", bus.data2send, 8'hA5);
      checkOutput("a5_valid_count", seenValid, 1);

      $display("[TB] reset mid-stream");
      applyStimulus(1'b1);
      midStreamReset();

      $display("[TB] failed lock");
      seenValid = 0;
      sendWord(COMMA);
      sendWord(COMMA);
      sendWord(8'h12);
      checkOutput("fail_active", bus.active, 0);
      checkOutput("fail_valid_count", seenValid, 0);
      for (int i = 0; i < 4; i++) sendWord(COMMA);
      checkOutput("relock_active", bus.active, 1);

      $display("[TB] idle commas");
      seenValid = 0;
      seenStrobe = 0;
      sendWord(8'h3C);
      sendWord(COMMA);
      checkOutput("idle_comma_data", bus.data2send, COMMA);
      sendWord(8'h7E);
      sendWord(COMMA);
      checkOutput("idle_valid_count", seenValid, 2);
      checkOutput("idle_strobe_count", seenStrobe, 4);

      $display("[TB] bit slip");
      applyStimulus(1'b0);
      for (int i = 0; i < 3; i++) sendWord(COMMA);
      checkOutput("slip_drop_active", bus.active, 0);
      for (int i = 0; i < 4; i++) sendWord(COMMA);
      checkOutput("slip_relock_active", bus.active, 1);

      $display("[TB] misaligned comma recovery");
      sendWord(8'h0B);
      sendWord(8'hC0);
      sendWord(COMMA);
      for (int i = 0; i < 2; i++) begin
         sendWord(8'h0B);
         sendWord(8'hC0);
      end
      checkOutput("recover_active", bus.active, 1);

      $display("[TB] random words");
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 15) == 0) applyStimulus(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 9) < 3) sendWord(COMMA);
         else sendWord(8'($urandom_range(0, 255)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
